i2c_slave_rx: RTL

//  Write-only I2C target (responder) matching the team's I2C_Master write path. Samples

---
 rtl/i2c_slave_rx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target. Oversamples SCL/SDA on clk, tracks START/STOP,
// matches a 7-bit address and hands each data byte to local logic through a
// valid/ready holding register with a sticky overrun flag.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | bus free, waiting for START
// DUMMY  | discarding the master's post-START pulse(s)
// ADDR   | shifting in the address byte (7-bit address + R/W)
// DATA   | addressed for write, shifting in data bytes
// IGNORE | not addressed (or read request), dropping bits until STOP/START
`timescale 1ns/1ps
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR   = 7'h50,
  parameter int         DUMMY_PULSES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic       rx_ready,
  input  logic       err_clear,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_hit,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DW = (DUMMY_PULSES > 1) ? $clog2(DUMMY_PULSES + 1) : 1;
  localparam logic [DW-1:0] DUMMY_LOAD = DW'(DUMMY_PULSES);

  typedef enum logic [2:0] {IDLE, DUMMY, ADDR, DATA, IGNORE} state_t;

  state_t          state, state_nxt;
  logic            scl_s1, scl_s2, scl_p;
  logic            sda_s1, sda_s2, sda_p;
  logic            bit_pend, bit_val;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg, shift_nxt;
  logic [DW-1:0]   dummy_cnt;
  logic            scl_rise, scl_fall, sda_rise, sda_fall;
  logic            start_det, stop_det, in_byte, commit, byte_done, data_done;
  logic            addr_ok, rx_hs;

  // Two-flop synchronizers plus a third flop holding the previous sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {scl_s1, scl_s2, scl_p} <= 3'b111;
      {sda_s1, sda_s2, sda_p} <= 3'b111;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      scl_p  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_p  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_p;
  assign scl_fall  = ~scl_s2 & scl_p;
  assign sda_rise  = sda_s2 & ~sda_p;
  assign sda_fall  = ~sda_s2 & sda_p;
  // Keyed on the previous SCL sample so a simultaneous SCL/SDA fall is a START.
  assign start_det = sda_fall & scl_p;
  assign stop_det  = sda_rise & scl_p & scl_s2;
  assign in_byte   = (state == ADDR) || (state == DATA);
  // A latched bit only counts once SCL falls without a START/STOP in between.
  assign commit    = scl_fall & bit_pend & ~start_det & ~stop_det;
  assign shift_nxt = {shreg[6:0], bit_val};
  assign byte_done = commit & in_byte & (bit_cnt == 3'd7);
  assign data_done = byte_done & (state == DATA);
  assign addr_ok   = (shift_nxt[7:1] == SLAVE_ADDR) && !shift_nxt[0];
  assign rx_hs     = rx_valid & rx_ready;
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; START and STOP override every state.
  always_comb begin
    state_nxt = state;
    if (start_det) begin
      state_nxt = (DUMMY_PULSES == 0) ? ADDR : DUMMY;
    end else if (stop_det) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        DUMMY:   if (commit && dummy_cnt == DW'(1)) state_nxt = ADDR;
        ADDR:    if (byte_done) state_nxt = addr_ok ? DATA : IGNORE;
        default: state_nxt = state;
      endcase
    end
  end

  // Bit capture, shift register, counters, address match and frame pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_pend   <= 1'b0;
      bit_val    <= 1'b0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      dummy_cnt  <= '0;
      addr_hit   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= stop_det & addr_hit;
      frame_err  <= (start_det | stop_det) & (bit_cnt != 3'd0);
      if (start_det || stop_det) begin
        bit_pend  <= 1'b0;
        bit_cnt   <= 3'd0;
        addr_hit  <= 1'b0;
        dummy_cnt <= DUMMY_LOAD;
      end else begin
        if (scl_rise) begin
          bit_pend <= 1'b1;
          bit_val  <= sda_s2;
        end else if (commit) begin
          bit_pend <= 1'b0;
        end
        if (commit && in_byte) begin
          shreg   <= shift_nxt;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (commit && state == DUMMY) dummy_cnt <= dummy_cnt - DW'(1);
        if (byte_done && state == ADDR && addr_ok) addr_hit <= 1'b1;
      end
    end
  end

  // Receive holding register; a same-cycle handshake makes room for the new byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else if (data_done && (!rx_valid || rx_hs)) begin
      rx_data  <= shift_nxt;
      rx_valid <= 1'b1;
    end else if (rx_hs) begin
      rx_valid <= 1'b0;
    end
  end

  // Sticky overrun; clearing wins over a simultaneous new overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      overrun <= 1'b0;
    else if (err_clear)                            overrun <= 1'b0;
    else if (data_done && rx_valid && !rx_ready)   overrun <= 1'b1;
  end

endmodule
